decode_stage: RTL and testbench

- Parametrised, registered decode stage between the fetch buffer and the issue queue.
- Latches a fetch bundle of up to DECODE_WIDTH instructions and compacts valid slots in program order.
- Each cycle, decodes the oldest held slots and pushes as many as the issue queue has room for.
- Partially pushed bundles are retained and shifted; fetch is back-pressured until the bundle drains.

---
 rtl/decode_stage.sv | 124 ++++++++++++
 tb/tb_decode_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered decode stage: captures a fetch bundle, compacts valid slots and feeds the issue queue.
// Optional performance counters are enabled with `define DECODE_STAGE_PERF_CNT_EN.
module decode_stage #(
  parameter int DECODE_WIDTH = 4,
  parameter int IQ_DEPTH     = 16,
  parameter int REQ_W        = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DECODE_WIDTH-1:0]                 in_slot_valid,
  input  logic [DECODE_WIDTH*REQ_W-1:0]           decode_require,
  output logic [DECODE_WIDTH*(REQ_W+2)-1:0]       issue_queue_element,
  output logic [$clog2(DECODE_WIDTH+1)-1:0]       issue_queue_push_number,
  input  logic [$clog2(IQ_DEPTH+1)-1:0]           iq_size_left,
  output logic [$clog2(DECODE_WIDTH+1)-1:0]       held_count
`ifdef DECODE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]                             perf_stall_cycles,
  output logic [31:0]                             perf_partial_push
`endif
);

  localparam int CW     = $clog2(DECODE_WIDTH + 1);
  localparam int ELEM_W = REQ_W + 2;

  logic [REQ_W-1:0] slot_reg [DECODE_WIDTH];
  logic [CW-1:0]    cnt_reg;

  logic [REQ_W-1:0] comp_slot  [DECODE_WIDTH];
  logic [REQ_W-1:0] shift_slot [DECODE_WIDTH];
  logic [CW-1:0]    comp_count;
  logic [CW-1:0]    avail;
  logic [CW-1:0]    push;
  logic             accept;

  // Element layout: {valid, is_reg_reg_alu, raw payload}
  function automatic logic [ELEM_W-1:0] decode_slot(input logic [REQ_W-1:0] r);
    decode_slot = {1'b1, (r[6:0] == 7'b0110011), r};
  endfunction

  always_comb begin
    if (int'(iq_size_left) > DECODE_WIDTH) avail = CW'(DECODE_WIDTH);
    else                                   avail = CW'(iq_size_left);
    if (flush)                push = '0;
    else if (cnt_reg < avail) push = cnt_reg;
    else                      push = avail;
  end

  assign in_ready                = !flush && (cnt_reg == push);
  assign accept                  = in_valid && in_ready;
  assign issue_queue_push_number = push;
  assign held_count              = cnt_reg;

  // Compaction: the j-th set bit of the mask lands in output slot j.
  always_comb begin
    int run;
    run = 0;
    for (int j = 0; j < DECODE_WIDTH; j++) comp_slot[j] = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (in_slot_valid[i]) begin
        for (int j = 0; j < DECODE_WIDTH; j++)
          if (run == j) comp_slot[j] = decode_require[i*REQ_W +: REQ_W];
        run = run + 1;
      end
    end
    comp_count = CW'(run);
  end

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      shift_slot[i] = '0;
      for (int s = 0; i + s < DECODE_WIDTH; s++)
        if (int'(push) == s) shift_slot[i] = slot_reg[i+s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      for (int i = 0; i < DECODE_WIDTH; i++) slot_reg[i] <= '0;
    end else if (flush) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= comp_count;
      for (int i = 0; i < DECODE_WIDTH; i++) slot_reg[i] <= comp_slot[i];
    end else begin
      cnt_reg <= cnt_reg - push;
      for (int i = 0; i < DECODE_WIDTH; i++) slot_reg[i] <= shift_slot[i];
    end
  end

  generate
    for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_dec
      assign issue_queue_element[gi*ELEM_W +: ELEM_W] =
        (gi < int'(push)) ? decode_slot(slot_reg[gi]) : '0;
    end
  endgenerate

`ifdef DECODE_STAGE_PERF_CNT_EN
  logic stall_evt;
  logic partial_evt;

  assign stall_evt   = (cnt_reg != '0) && (push < cnt_reg);
  assign partial_evt = (push != '0) && (push < cnt_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_partial_push <= '0;
    end else begin
      if (stall_evt && (perf_stall_cycles != '1))   perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (partial_evt && (perf_partial_push != '1)) perf_partial_push <= perf_partial_push + 32'd1;
    end
  end
`endif

  a_push_le_cnt: assert property (@(posedge clk) disable iff (!rst_n) push <= cnt_reg);
  a_push_le_iq:  assert property (@(posedge clk) disable iff (!rst_n) int'(push) <= int'(iq_size_left));
  a_cnt_le_w:    assert property (@(posedge clk) disable iff (!rst_n) int'(cnt_reg) <= DECODE_WIDTH);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed and random cycles checked against a queue-based model.
// Performance counter checks are active when DECODE_STAGE_PERF_CNT_EN is defined.
module tb_decode_stage;
  localparam int W  = 4;
  localparam int RW = 32;
  localparam int EW = RW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_slot_valid;
  logic [W*RW-1:0] decode_require;
  logic [W*EW-1:0] issue_queue_element;
  logic [2:0]    issue_queue_push_number;
  logic [4:0]    iq_size_left;
  logic [2:0]    held_count;
`ifdef DECODE_STAGE_PERF_CNT_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_partial_push;
`endif

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] mq [$];
  int exp_stall = 0;
  int exp_part  = 0;

  always #5 clk = ~clk;

  decode_stage #(.DECODE_WIDTH(W), .IQ_DEPTH(16), .REQ_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .decode_require(decode_require),
    .issue_queue_element(issue_queue_element), .issue_queue_push_number(issue_queue_push_number),
    .iq_size_left(iq_size_left), .held_count(held_count)
`ifdef DECODE_STAGE_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_partial_push(perf_partial_push)
`endif
  );

  function automatic logic [EW-1:0] dec(input logic [RW-1:0] r);
    dec = {1'b1, (r[6:0] == 7'b0110011), r};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_perf();
`ifdef DECODE_STAGE_PERF_CNT_EN
    check("perf_stall", 256'(perf_stall_cycles), 256'(exp_stall));
    check("perf_partial", 256'(perf_partial_push), 256'(exp_part));
`endif
  endtask

  // One cycle: drive at negedge, compare before the next posedge, then advance the model.
  task automatic step(input logic f, input logic v, input logic [W-1:0] m, input int iq);
    int avail, p, sz;
    logic rdy;
    logic [W*EW-1:0] ee;
    @(negedge clk);
    flush = f; in_valid = v; in_slot_valid = m; iq_size_left = 5'(iq);
    for (int i = 0; i < W; i++) begin
      logic [RW-1:0] r;
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[6:0] = 7'b0110011;
      decode_require[i*RW +: RW] = r;
    end
    #1;
    sz    = mq.size();
    avail = (iq > W) ? W : iq;
    p     = f ? 0 : ((sz < avail) ? sz : avail);
    rdy   = !f && (sz - p == 0);
    ee    = '0;
    for (int k = 0; k < p; k++) ee[k*EW +: EW] = dec(mq[k]);
    check("push_number", 256'(issue_queue_push_number), 256'(p));
    check("in_ready", 256'(in_ready), 256'(rdy));
    check("held_count", 256'(held_count), 256'(sz));
    check("elements", 256'(issue_queue_element), 256'(ee));
    check_perf();
    $display("cyc flush=%0b valid=%0b mask=%b iq=%0d held=%0d push=%0d ready=%0b",
             f, v, m, iq, sz, p, rdy);
    if (sz > 0 && p < sz) exp_stall++;
    if (p > 0 && p < sz)  exp_part++;
    @(posedge clk);
    if (f) mq.delete();
    else if (v && rdy) begin
      mq.delete();
      for (int i = 0; i < W; i++) if (m[i]) mq.push_back(decode_require[i*RW +: RW]);
    end else begin
      for (int k = 0; k < p; k++) void'(mq.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_slot_valid = '0;
    decode_require = '0; iq_size_left = 5'd8;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 256'(in_ready), 256'(1));
    check("rst_push", 256'(issue_queue_push_number), 256'(0));
    check("rst_held", 256'(held_count), 256'(0));
    check("rst_elem", 256'(issue_queue_element), 256'(0));
    @(negedge clk); rst_n = 1'b1;

    step(0, 0, 4'h0, 8);                 // idle
    step(0, 1, 4'hf, 8);                 // full bundle
    step(0, 1, 4'hf, 8);                 // drain + refill same cycle
    step(0, 0, 4'h0, 8);
    step(0, 1, 4'b1010, 8);              // sparse mask compaction
    step(0, 0, 4'h0, 8);
    step(0, 1, 4'h0, 8);                 // empty mask accepted
    step(0, 1, 4'hf, 0);                 // partial drains 1,0,3
    step(0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 0);
    step(0, 0, 4'h0, 3);
    step(0, 0, 4'h0, 20);                // saturation above W
    step(0, 1, 4'hf, 8);                 // held then flushed
    step(0, 0, 4'h0, 0);
    step(1, 1, 4'hf, 8);
    step(0, 0, 4'h0, 8);
    step(0, 1, 4'hf, 8);                 // drain one per cycle
    repeat (4) step(0, 0, 4'h0, 1);
    step(0, 0, 4'h0, 8);

    // Asynchronous reset while stalled
    step(0, 1, 4'hf, 0);
    step(0, 0, 4'h0, 0);
    @(negedge clk);
    rst_n = 1'b0; iq_size_left = 5'd8; flush = 1'b0; in_valid = 1'b0;
    #1;
    mq.delete(); exp_stall = 0; exp_part = 0;
    check("midrst_held", 256'(held_count), 256'(0));
    check("midrst_push", 256'(issue_queue_push_number), 256'(0));
    check("midrst_ready", 256'(in_ready), 256'(1));
    check_perf();
    @(negedge clk); rst_n = 1'b1;

    for (int n = 0; n < 300; n++)
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), $urandom_range(0, 20));

    @(negedge clk); #1;
    check_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
